bpd_bob: RTL and testbench
==========================

# bpd_bob

Branch order buffer feeding retire-time updates to the tournament branch predictor. It records, in program order, each conditional branch the front end predicts: its PC, its global history (BHR) snapshot, its local history and its prediction. It then accepts out-of-order resolutions from execute. Entries retire in order, and each retirement drives the predictor's PHT/BHR update and misprediction-flush port.

## Interface
- DEPTH, 8: number of entries; power of two, at least 2
- PTR_W, 3: log2(DEPTH)

Ports:
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-high
- alloc_valid_i  in  1  front end predicted a conditional branch this cycle
- alloc_pc_i  in  64  branch PC
- alloc_bhr_i  in  12  BHR value used for the prediction, before the shift
- alloc_lochist_i  in  10  local history used for the prediction
- alloc_pred_i  in  1  final predicted direction
- alloc_ready_o  out  1  buffer not full
- alloc_tag_o  out  PTR_W  tag given to the branch allocated at the next edge (the current tail)
- res_valid_i  in  1  execute resolved a branch
- res_tag_i  in  PTR_W  tag of the resolved branch
- res_brdir_i  in  1  actual direction
- ext_flush_i  in  1  non-branch pipeline flush (exception/trap)
- bpd_rt_ud_o  out  1  one-cycle retire-update strobe
- bpd_rt_brdir_o  out  1  actual direction of the retiring branch
- bob_pc_r_o  out  64  PC of the retiring branch
- bob_bhr_r_o  out  12  BHR snapshot of the retiring branch
- bob_lochist_r_o  out  10  local history of the retiring branch
- bob_valid_r_o  out  1  retire outputs carry a valid entry this cycle
- flush_o  out  1  predictor flush strobe
- count_o  out  PTR_W+1  occupied entries

## Operation
- Storage is a circular buffer with head (oldest) and tail pointers, each PTR_W bits and wrapping modulo DEPTH. Each entry also holds valid, resolved, pred and actual-direction bits.
- **Allocate:** alloc_valid_i && alloc_ready_o writes the entry at tail, sets valid=1 and resolved=0, and increments tail. When alloc_ready_o=0 the request is dropped silently.
- **Resolve:** res_valid_i writes the actual direction into entry res_tag_i and sets resolved=1. The write is ignored if the entry is invalid or already resolved.
- **Retire:**
  - Retirement is evaluated every cycle from registered state. When head is valid and resolved, the head entry is popped and all retire outputs are registered.
  - A mispredict is actual != pred. On a mispredict retire, flush_o=1 in the same output cycle as bpd_rt_ud_o=1, so the predictor reloads the BHR as {bob_bhr_r_o[10:0], bpd_rt_brdir_o}.
  - A mispredict retire invalidates all remaining entries and sets tail=head+1 (the buffer is empty after the edge).
- **ext_flush_i:** invalidates every entry and sets tail=head. The next output cycle shows flush_o=1, bob_valid_r_o=0 and bpd_rt_ud_o=0. It has priority over retire, resolve and allocate in the same edge.
- **Allocate drop rule:** allocations sampled on a mispredict-retire edge, or while flush_o=1, are dropped; they are wrong-path.
- **Output hold:** bob_pc_r_o, bob_bhr_r_o and bob_lochist_r_o hold the last retired values when nothing retires.
- **Per-edge limits:** at most one allocation, one resolution and one retirement per edge.
- **Reset values:** every output is 0, except alloc_ready_o=1. All entries are invalid and the pointers are 0.

## Timing
- alloc_ready_o = (count < DEPTH), a function of registered count only. When full it stays 0 even if a retire happens in the same cycle.
- alloc_tag_o is combinational from tail.
- Resolve sampled at edge E: if that entry is the head, the retire outputs are valid in the cycle after edge E+1. Best-case allocate-to-retire is therefore 3 edges.
- Retire outputs are registered.
- bpd_rt_ud_o, flush_o and bob_valid_r_o are single-cycle pulses.
- count_o updates at the edge, as +1 for alloc and −1 for retire (net 0 when both happen), or to 0 on a flush.
- Reset asserted mid-operation clears the buffer immediately (asynchronous). No retire pulse is emitted.

## Test plan
- **In-order retire:**
  - Stimulus: allocate 3 branches (pc 0x100, 0x104, 0x108; pred 1,0,1), then resolve them in order 1,0,1.
  - Required: three rt_ud pulses with matching PCs and BHRs, flush_o always 0, count_o back to 0.
- **Out-of-order resolve:**
  - Stimulus: allocate tags 0,1,2, then resolve 2, 1, 0.
  - Required: no retire until tag 0 resolves. Then tags 0,1,2 retire on three consecutive cycles.
- **Mispredict:**
  - Stimulus: allocate 4 branches; tag 0 has pred=1 and is resolved 0.
  - Required: one cycle with rt_ud=1, brdir=0, flush_o=1 and bob_valid_r_o=1. count_o=0 afterwards. A later resolve of tag 2 is ignored.
- **Full:**
  - Stimulus: allocate DEPTH=8 branches, then attempt a 9th.
  - Required: alloc_ready_o=0 and count_o=8; the 9th is dropped. After one retire, alloc_ready_o=1 and alloc_tag_o=0 (wrap-around).
- **Ext flush:**
  - Stimulus: with 5 entries, one of them resolved at the head, assert ext_flush_i.
  - Required: flush_o=1, bob_valid_r_o=0 and rt_ud=0 next cycle; count_o=0.
- **Reset:**
  - Stimulus: assert reset_n mid-stream.
  - Required: immediate return to reset values, with no spurious strobes after release.

Source files
------------

// File: rtl/bpd_bob.sv
// rtl/bpd_bob.sv - branch order buffer: in-order record, out-of-order resolve,
// in-order retire driving predictor PHT/BHR updates and mispredict flushes.
module bpd_bob #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alloc_valid_i,
  input  logic [63:0]      alloc_pc_i,
  input  logic [11:0]      alloc_bhr_i,
  input  logic [9:0]       alloc_lochist_i,
  input  logic             alloc_pred_i,
  output logic             alloc_ready_o,
  output logic [PTR_W-1:0] alloc_tag_o,
  input  logic             res_valid_i,
  input  logic [PTR_W-1:0] res_tag_i,
  input  logic             res_brdir_i,
  input  logic             ext_flush_i,
  output logic             bpd_rt_ud_o,
  output logic             bpd_rt_brdir_o,
  output logic [63:0]      bob_pc_r_o,
  output logic [11:0]      bob_bhr_r_o,
  output logic [9:0]       bob_lochist_r_o,
  output logic             bob_valid_r_o,
  output logic             flush_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [63:0]      pc_mem  [DEPTH];
  logic [11:0]      bhr_mem [DEPTH];
  logic [9:0]       loc_mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] resolved_q;
  logic [DEPTH-1:0] pred_q;
  logic [DEPTH-1:0] act_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  logic retire;
  logic mispredict;
  logic alloc_fire;
  logic res_fire;

  assign alloc_ready_o = (count_q < FULL_COUNT);
  assign alloc_tag_o   = tail_q;
  assign count_o       = count_q;

  // ext flush wins over everything; wrong-path allocations are dropped
  assign retire     = valid_q[head_q] & resolved_q[head_q] & ~ext_flush_i;
  assign mispredict = retire & (act_q[head_q] != pred_q[head_q]);
  assign alloc_fire = alloc_valid_i & alloc_ready_o & ~flush_o & ~mispredict & ~ext_flush_i;
  assign res_fire   = res_valid_i & valid_q[res_tag_i] & ~resolved_q[res_tag_i] & ~ext_flush_i;

  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      pc_mem[tail_q]  <= alloc_pc_i;
      bhr_mem[tail_q] <= alloc_bhr_i;
      loc_mem[tail_q] <= alloc_lochist_i;
    end
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      valid_q         <= '0;
      resolved_q      <= '0;
      pred_q          <= '0;
      act_q           <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      bpd_rt_ud_o     <= 1'b0;
      bpd_rt_brdir_o  <= 1'b0;
      bob_pc_r_o      <= '0;
      bob_bhr_r_o     <= '0;
      bob_lochist_r_o <= '0;
      bob_valid_r_o   <= 1'b0;
      flush_o         <= 1'b0;
    end else begin
      if (res_fire) begin
        resolved_q[res_tag_i] <= 1'b1;
        act_q[res_tag_i]      <= res_brdir_i;
      end
      if (alloc_fire) begin
        valid_q[tail_q]    <= 1'b1;
        resolved_q[tail_q] <= 1'b0;
        pred_q[tail_q]     <= alloc_pred_i;
        tail_q             <= tail_q + 1'b1;
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + {{PTR_W{1'b0}}, alloc_fire} - {{PTR_W{1'b0}}, retire};

      // a flush overrides the per-entry updates above
      if (ext_flush_i) begin
        valid_q <= '0;
        tail_q  <= head_q;
        count_q <= '0;
      end else if (mispredict) begin
        valid_q <= '0;
        tail_q  <= head_q + 1'b1;
        count_q <= '0;
      end

      bpd_rt_ud_o   <= retire;
      bob_valid_r_o <= retire;
      flush_o       <= ext_flush_i | mispredict;
      if (retire) begin
        bpd_rt_brdir_o  <= act_q[head_q];
        bob_pc_r_o      <= pc_mem[head_q];
        bob_bhr_r_o     <= bhr_mem[head_q];
        bob_lochist_r_o <= loc_mem[head_q];
      end
    end
  end

endmodule

// File: tb/tb_bpd_bob.sv
// tb/tb_bpd_bob.sv - bench for bpd_bob: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_bpd_bob;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             alloc_valid_i = 1'b0;
  logic [63:0]      alloc_pc_i = '0;
  logic [11:0]      alloc_bhr_i = '0;
  logic [9:0]       alloc_lochist_i = '0;
  logic             alloc_pred_i = 1'b0;
  logic             alloc_ready_o;
  logic [PTR_W-1:0] alloc_tag_o;
  logic             res_valid_i = 1'b0;
  logic [PTR_W-1:0] res_tag_i = '0;
  logic             res_brdir_i = 1'b0;
  logic             ext_flush_i = 1'b0;
  logic             bpd_rt_ud_o;
  logic             bpd_rt_brdir_o;
  logic [63:0]      bob_pc_r_o;
  logic [11:0]      bob_bhr_r_o;
  logic [9:0]       bob_lochist_r_o;
  logic             bob_valid_r_o;
  logic             flush_o;
  logic [PTR_W:0]   count_o;

  int checks = 0;
  int failures = 0;

  bpd_bob #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_bhr_i(alloc_bhr_i),
    .alloc_lochist_i(alloc_lochist_i), .alloc_pred_i(alloc_pred_i),
    .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .res_valid_i(res_valid_i), .res_tag_i(res_tag_i), .res_brdir_i(res_brdir_i),
    .ext_flush_i(ext_flush_i),
    .bpd_rt_ud_o(bpd_rt_ud_o), .bpd_rt_brdir_o(bpd_rt_brdir_o),
    .bob_pc_r_o(bob_pc_r_o), .bob_bhr_r_o(bob_bhr_r_o), .bob_lochist_r_o(bob_lochist_r_o),
    .bob_valid_r_o(bob_valid_r_o), .flush_o(flush_o), .count_o(count_o)
  );

  always #5 clock = ~clock;

  // reference model: program-order queue of in-flight branches
  typedef struct {
    int          tag;
    logic [63:0] pc;
    logic [11:0] bhr;
    logic [9:0]  loc;
    logic        pred;
    logic        act;
    logic        res;
  } ent_t;

  ent_t        mq[$];
  int          m_head, m_tail;
  logic        m_ud, m_fl, m_vld, m_dir;
  logic [63:0] m_pc;
  logic [11:0] m_bhr;
  logic [9:0]  m_loc;

  task automatic model_reset();
    mq.delete();
    m_head = 0; m_tail = 0;
    m_ud = 0; m_fl = 0; m_vld = 0; m_dir = 0;
    m_pc = '0; m_bhr = '0; m_loc = '0;
  endtask

  task automatic model_step();
    logic prev_fl, retire, mis, do_alloc;
    ent_t e;
    prev_fl = m_fl;
    if (ext_flush_i) begin
      mq.delete();
      m_tail = m_head;
      m_ud = 0; m_vld = 0; m_fl = 1;
      return;
    end
    retire   = (mq.size() > 0) && mq[0].res;
    mis      = retire && (mq[0].act != mq[0].pred);
    do_alloc = alloc_valid_i && (mq.size() < DEPTH) && !prev_fl && !mis;
    m_ud = retire; m_vld = retire; m_fl = mis;
    if (retire) begin
      e = mq.pop_front();
      m_pc = e.pc; m_bhr = e.bhr; m_loc = e.loc; m_dir = e.act;
      m_head = (m_head + 1) % DEPTH;
      if (mis) begin
        mq.delete();
        m_tail = m_head;
      end
    end
    if (res_valid_i)
      foreach (mq[i])
        if (mq[i].tag == int'(res_tag_i) && !mq[i].res) begin
          mq[i].act = res_brdir_i;
          mq[i].res = 1'b1;
        end
    if (do_alloc) begin
      e.tag = m_tail; e.pc = alloc_pc_i; e.bhr = alloc_bhr_i; e.loc = alloc_lochist_i;
      e.pred = alloc_pred_i; e.act = 1'b0; e.res = 1'b0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) model_step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    alloc_valid_i = 0; res_valid_i = 0; ext_flush_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
  endtask

  task automatic alloc(input logic [63:0] pc, input logic [11:0] bhr, input logic [9:0] loc,
                       input logic pred);
    alloc_valid_i = 1; alloc_pc_i = pc; alloc_bhr_i = bhr; alloc_lochist_i = loc; alloc_pred_i = pred;
    tick();
    alloc_valid_i = 0;
  endtask

  task automatic resolve(input int tag, input logic dir);
    res_valid_i = 1; res_tag_i = PTR_W'(tag); res_brdir_i = dir;
    tick();
    res_valid_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bpd_rt_ud_o, bpd_rt_brdir_o, bob_valid_r_o, flush_o} !== 4'b0 || count_o !== 0 ||
        bob_pc_r_o !== 0 || bob_bhr_r_o !== 0 || bob_lochist_r_o !== 0 || alloc_tag_o !== 0) begin
      failures++;
      $display("FAIL reset_outputs actual ud=%b fl=%b v=%b cnt=%0d pc=%0h tag=%0d required all zero",
               bpd_rt_ud_o, flush_o, bob_valid_r_o, count_o, bob_pc_r_o, alloc_tag_o);
    end
    checks++;
    if (alloc_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready actual=%b required=1", alloc_ready_o);
    end
  endtask

  task automatic test_in_order();
    logic [63:0] pcs [3];
    logic [11:0] bhrs [3];
    int n;
    logic saw_fl;
    pcs = '{64'h100, 64'h104, 64'h108};
    n = 0; saw_fl = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bhrs[i] = 12'($urandom);
      alloc(pcs[i], bhrs[i], 10'(i), (i != 1));
    end
    checks++;
    if (count_o !== 3) begin
      failures++;
      $display("FAIL in_order_count3 actual=%0d required=3", count_o);
    end
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        res_valid_i = 1; res_tag_i = PTR_W'(c); res_brdir_i = (c != 1);
      end else res_valid_i = 0;
      tick();
      if (flush_o) saw_fl = 1;
      if (bpd_rt_ud_o) begin
        checks++;
        if (n >= 3 || bob_pc_r_o !== pcs[n] || bob_bhr_r_o !== bhrs[n]) begin
          failures++;
          $display("FAIL in_order_retire%0d actual pc=%0h bhr=%0h required pc=%0h bhr=%0h",
                   n, bob_pc_r_o, bob_bhr_r_o, (n < 3) ? pcs[n] : 64'h0, (n < 3) ? bhrs[n] : 12'h0);
        end
        n++;
      end
    end
    res_valid_i = 0;
    checks++;
    if (n != 3 || saw_fl || count_o !== 0) begin
      failures++;
      $display("FAIL in_order_summary actual pulses=%0d flush=%b cnt=%0d required 3/0/0", n, saw_fl, count_o);
    end
  endtask

  task automatic test_out_of_order();
    logic [63:0] pcs [3];
    pcs = '{64'h2000, 64'h2010, 64'h2020};
    do_reset();
    for (int i = 0; i < 3; i++) alloc(pcs[i], 12'($urandom), 10'($urandom), 1'b0);
    for (int t = 2; t >= 0; t--) begin
      resolve(t, 1'b0);
      checks++;
      if (bpd_rt_ud_o !== 1'b0) begin
        failures++;
        $display("FAIL ooo_early_retire tag=%0d actual=%b required=0", t, bpd_rt_ud_o);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bpd_rt_ud_o !== 1'b1 || bob_pc_r_o !== pcs[k] || flush_o !== 1'b0) begin
        failures++;
        $display("FAIL ooo_retire%0d actual ud=%b pc=%0h fl=%b required ud=1 pc=%0h fl=0",
                 k, bpd_rt_ud_o, bob_pc_r_o, flush_o, pcs[k]);
      end
    end
    tick();
    checks++;
    if (bpd_rt_ud_o !== 1'b0 || count_o !== 0 || bob_pc_r_o !== pcs[2]) begin
      failures++;
      $display("FAIL ooo_after actual ud=%b cnt=%0d pc=%0h required ud=0 cnt=0 pc=%0h",
               bpd_rt_ud_o, count_o, bob_pc_r_o, pcs[2]);
    end
  endtask

  task automatic test_mispredict();
    logic saw_ud;
    saw_ud = 0;
    do_reset();
    alloc(64'h3000, 12'h5a5, 10'h11, 1'b1);
    for (int i = 1; i < 4; i++) alloc(64'h3000 + 64'(4 * i), 12'($urandom), 10'($urandom), 1'($urandom));
    resolve(0, 1'b0);
    tick();
    checks++;
    if (bpd_rt_ud_o !== 1'b1 || bpd_rt_brdir_o !== 1'b0 || flush_o !== 1'b1 || bob_valid_r_o !== 1'b1 ||
        bob_bhr_r_o !== 12'h5a5) begin
      failures++;
      $display("FAIL mispredict_pulse actual ud=%b dir=%b fl=%b v=%b bhr=%0h required 1/0/1/1/5a5",
               bpd_rt_ud_o, bpd_rt_brdir_o, flush_o, bob_valid_r_o, bob_bhr_r_o);
    end
    checks++;
    if (count_o !== 0 || alloc_tag_o !== 1) begin
      failures++;
      $display("FAIL mispredict_empty actual cnt=%0d tag=%0d required cnt=0 tag=1", count_o, alloc_tag_o);
    end
    resolve(2, 1'b1);
    repeat (3) begin
      if (bpd_rt_ud_o) saw_ud = 1;
      tick();
    end
    checks++;
    if (saw_ud || count_o !== 0) begin
      failures++;
      $display("FAIL mispredict_stale_resolve actual ud_seen=%b cnt=%0d required 0/0", saw_ud, count_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(64'h4000 + 64'(i), 12'($urandom), 10'($urandom), 1'b1);
    checks++;
    if (alloc_ready_o !== 1'b0 || count_o !== DEPTH) begin
      failures++;
      $display("FAIL full_state actual rdy=%b cnt=%0d required rdy=0 cnt=%0d", alloc_ready_o, count_o, DEPTH);
    end
    alloc(64'hdead, 12'h0, 10'h0, 1'b1);
    checks++;
    if (count_o !== DEPTH || alloc_tag_o !== 0) begin
      failures++;
      $display("FAIL full_drop actual cnt=%0d tag=%0d required cnt=%0d tag=0", count_o, alloc_tag_o, DEPTH);
    end
    resolve(0, 1'b1);
    tick();
    checks++;
    if (bpd_rt_ud_o !== 1'b1 || bob_pc_r_o !== 64'h4000 || count_o !== DEPTH - 1 ||
        alloc_ready_o !== 1'b1 || alloc_tag_o !== 0) begin
      failures++;
      $display("FAIL full_after_retire actual ud=%b pc=%0h cnt=%0d rdy=%b tag=%0d required 1/4000/%0d/1/0",
               bpd_rt_ud_o, bob_pc_r_o, count_o, alloc_ready_o, alloc_tag_o, DEPTH - 1);
    end
  endtask

  task automatic test_ext_flush();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(64'h5000 + 64'(i), 12'($urandom), 10'($urandom), 1'b0);
    resolve(0, 1'b0);
    ext_flush_i = 1;
    tick();
    ext_flush_i = 0;
    checks++;
    if (flush_o !== 1'b1 || bob_valid_r_o !== 1'b0 || bpd_rt_ud_o !== 1'b0 || count_o !== 0 ||
        alloc_tag_o !== 0) begin
      failures++;
      $display("FAIL ext_flush actual fl=%b v=%b ud=%b cnt=%0d tag=%0d required 1/0/0/0/0",
               flush_o, bob_valid_r_o, bpd_rt_ud_o, count_o, alloc_tag_o);
    end
    alloc(64'hbad, 12'h0, 10'h0, 1'b0);
    checks++;
    if (count_o !== 0 || flush_o !== 1'b0) begin
      failures++;
      $display("FAIL ext_flush_drop actual cnt=%0d fl=%b required cnt=0 fl=0", count_o, flush_o);
    end
    alloc(64'h600, 12'h0, 10'h0, 1'b0);
    checks++;
    if (count_o !== 1 || alloc_tag_o !== 1) begin
      failures++;
      $display("FAIL ext_flush_realloc actual cnt=%0d tag=%0d required cnt=1 tag=1", count_o, alloc_tag_o);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    bad = 0;
    do_reset();
    alloc(64'h700, 12'h1, 10'h1, 1'b0);
    resolve(0, 1'b0);
    alloc(64'h704, 12'h2, 10'h2, 1'b1);
    alloc(64'h708, 12'h3, 10'h3, 1'b1);
    resolve(1, 1'b1);
    #2 reset_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (count_o !== 0 || alloc_ready_o !== 1'b1 || alloc_tag_o !== 0 || bob_pc_r_o !== 0 ||
        bpd_rt_ud_o !== 1'b0 || flush_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_immediate actual cnt=%0d rdy=%b tag=%0d pc=%0h ud=%b fl=%b required 0/1/0/0/0/0",
               count_o, alloc_ready_o, alloc_tag_o, bob_pc_r_o, bpd_rt_ud_o, flush_o);
    end
    @(negedge clock);
    reset_n = 1'b0;
    repeat (4) begin
      tick();
      if (bpd_rt_ud_o || flush_o || bob_valid_r_o || count_o != 0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_spurious actual strobe_or_count_seen=1 required=0");
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      alloc_valid_i   = ($urandom_range(0, 9) < 6);
      alloc_pc_i      = {$urandom, $urandom};
      alloc_bhr_i     = 12'($urandom);
      alloc_lochist_i = 10'($urandom);
      alloc_pred_i    = 1'($urandom);
      res_valid_i     = ($urandom_range(0, 1) == 1);
      res_tag_i       = PTR_W'($urandom);
      res_brdir_i     = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      ext_flush_i     = ($urandom_range(0, 40) == 0);
      tick();
      checks++;
      if (bpd_rt_ud_o !== m_ud || flush_o !== m_fl || bob_valid_r_o !== m_vld ||
          count_o !== (PTR_W + 1)'(mq.size()) || alloc_ready_o !== (mq.size() < DEPTH) ||
          alloc_tag_o !== PTR_W'(m_tail) || bob_pc_r_o !== m_pc || bob_bhr_r_o !== m_bhr ||
          bob_lochist_r_o !== m_loc || (m_ud && bpd_rt_brdir_o !== m_dir)) begin
        failures++;
        if (errs < 10)
          $display("FAIL random_cycle%0d actual ud=%b fl=%b v=%b cnt=%0d tag=%0d pc=%0h dir=%b required ud=%b fl=%b v=%b cnt=%0d tag=%0d pc=%0h dir=%b",
                   c, bpd_rt_ud_o, flush_o, bob_valid_r_o, count_o, alloc_tag_o, bob_pc_r_o, bpd_rt_brdir_o,
                   m_ud, m_fl, m_vld, mq.size(), m_tail, m_pc, m_dir);
        errs++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_in_order();
    test_out_of_order();
    test_mispredict();
    test_full();
    test_ext_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
